// File: rtl/debug_pkg.sv
// Shared state encoding, command bytes and defaults for the debug dump sequencer.
package debug_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_RUN        = 4'd1,
    ST_STEP       = 4'd2,
    ST_SEND_PC    = 4'd3,
    ST_SEND_REG   = 4'd4,
    ST_SEND_MEM   = 4'd5,
    ST_SEND_LATCH = 4'd6,
    ST_SEND_CSUM  = 4'd7,
    ST_WAIT       = 4'd8,
    ST_DONE       = 4'd9
  } state_t;

  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_HALT = 8'h48;

  localparam int          DEFAULT_NUM_STAGES = 5;
  localparam logic [19:0] DEFAULT_STAGE_SIGS = {4'd2, 4'd6, 4'd6, 4'd4, 4'd2};

  function automatic logic is_send(input state_t s);
    return (s == ST_SEND_PC) || (s == ST_SEND_REG) || (s == ST_SEND_MEM) ||
           (s == ST_SEND_LATCH) || (s == ST_SEND_CSUM);
  endfunction

endpackage

// File: rtl/debug_dump_sequencer_if.sv
// Command, snapshot-read and UART transmit signals of the debug dump sequencer.
interface debug_dump_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              cmd_valid;
  logic [7:0]        cmd;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] reg_data;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] latch_data;
  logic              tx_ready;
  logic [REG_AW-1:0] reg_addr;
  logic [DATA_W-1:0] mem_addr;
  logic [2:0]        latch_stage;
  logic [3:0]        latch_sig;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              debug_on;
  logic              stop_pc;
  logic              busy;

  modport master (
    input  cmd_valid, cmd, pc, reg_data, mem_data, latch_data, tx_ready,
    output reg_addr, mem_addr, latch_stage, latch_sig, tx_start, tx_data,
           debug_on, stop_pc, busy
  );

  modport slave (
    output cmd_valid, cmd, pc, reg_data, mem_data, latch_data, tx_ready,
    input  reg_addr, mem_addr, latch_stage, latch_sig, tx_start, tx_data,
           debug_on, stop_pc, busy
  );
endinterface

// File: rtl/debug_latch_walker.sv
// Stage/signal select counter for the pipeline-latch part of a dump.
// last flags the final signal of the final stage.
module debug_latch_walker
  import debug_pkg::*;
#(
  parameter int                        NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter logic [4*NUM_STAGES-1:0]   STAGE_SIGS = DEFAULT_STAGE_SIGS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  output logic [2:0] stage,
  output logic [3:0] sig,
  output logic       last
);

  logic [2:0] stage_r;
  logic [3:0] sig_r;
  logic [3:0] lim_s;
  logic       stage_end_s;

  function automatic logic [3:0] stage_limit(input logic [2:0] s);
    logic [3:0] l;
    l = 4'd1;
    for (int i = 0; i < NUM_STAGES; i++) begin
      l = (s == 3'(i)) ? STAGE_SIGS[4*i +: 4] : l;
    end
    return l;
  endfunction

  // Limit lookup and end-of-stage / end-of-walk flags.
  always_comb begin
    lim_s       = stage_limit(stage_r);
    stage_end_s = (sig_r == (lim_s - 4'd1));
    last        = stage_end_s && (stage_r == 3'(NUM_STAGES - 1));
  end

  // Counter pair: sig rolls into the next stage, whole walk rolls back to (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_r <= 3'd0;
      sig_r   <= 4'd0;
    end else if (clr) begin
      stage_r <= 3'd0;
      sig_r   <= 4'd0;
    end else if (adv) begin
      if (last) begin
        stage_r <= 3'd0;
        sig_r   <= 4'd0;
      end else if (stage_end_s) begin
        stage_r <= stage_r + 3'd1;
        sig_r   <= 4'd0;
      end else begin
        sig_r   <= sig_r + 4'd1;
      end
    end
  end

  assign stage = stage_r;
  assign sig   = sig_r;

endmodule

// File: rtl/debug_dump_sequencer.sv
// Command-driven halt/step/run control and snapshot streamer toward the UART.
// Optional trailing XOR checksum word: define DEBUG_CHECKSUM_EN.
module debug_dump_sequencer
  import debug_pkg::*;
#(
  parameter int                      DATA_W     = 32,
  parameter int                      NUM_REGS   = 32,
  parameter logic [DATA_W-1:0]       MEM_BASE   = '0,
  parameter int                      MEM_WORDS  = 20,
  parameter int                      NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter logic [4*NUM_STAGES-1:0] STAGE_SIGS = DEFAULT_STAGE_SIGS
) (
  input  logic                   clk,
  input  logic                   rst,
  debug_dump_sequencer_if.master bus
);

  localparam int                REG_AW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [REG_AW-1:0] REG_LAST = REG_AW'(NUM_REGS - 1);
  localparam logic [DATA_W-1:0] MEM_LAST = MEM_BASE + DATA_W'(MEM_WORDS - 1);

  state_t            state_r, state_s, cur_send_r;
  logic              from_run_r;
  logic [REG_AW-1:0] reg_addr_r;
  logic [DATA_W-1:0] mem_addr_r;
  logic              tx_start_r;
  logic [DATA_W-1:0] tx_data_r;
  logic              debug_on_r, stop_pc_r, busy_r;
  logic [DATA_W-1:0] word_s;
  logic              ready_ok_s, dump_start_s;
  logic              walk_clr_s, walk_adv_s, walk_last_s;
  logic [2:0]        walk_stage_s;
  logic [3:0]        walk_sig_s;

`ifdef DEBUG_CHECKSUM_EN
  logic [DATA_W-1:0] csum_r;
`endif

  debug_latch_walker #(
    .NUM_STAGES (NUM_STAGES),
    .STAGE_SIGS (STAGE_SIGS)
  ) u_walker (
    .clk   (clk),
    .rst   (rst),
    .clr   (walk_clr_s),
    .adv   (walk_adv_s),
    .stage (walk_stage_s),
    .sig   (walk_sig_s),
    .last  (walk_last_s)
  );

  // Next-state and transmit-word selection.
  always_comb begin
    state_s      = state_r;
    word_s       = '0;
    // A ready pulse overlapping our own tx_start belongs to no word of ours.
    ready_ok_s   = (state_r == ST_WAIT) && bus.tx_ready && !tx_start_r;
    walk_clr_s   = (state_r == ST_DONE);
    walk_adv_s   = ready_ok_s && (cur_send_r == ST_SEND_LATCH);
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            CMD_RUN:  state_s = ST_RUN;
            CMD_STEP: state_s = ST_STEP;
            CMD_DUMP: state_s = ST_SEND_PC;
            default:  state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            CMD_HALT: state_s = ST_IDLE;
            CMD_DUMP: state_s = ST_SEND_PC;
            default:  state_s = ST_RUN;
          endcase
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_STEP:       state_s = ST_SEND_PC;
      ST_SEND_PC:    begin word_s = bus.pc;         state_s = ST_WAIT; end
      ST_SEND_REG:   begin word_s = bus.reg_data;   state_s = ST_WAIT; end
      ST_SEND_MEM:   begin word_s = bus.mem_data;   state_s = ST_WAIT; end
      ST_SEND_LATCH: begin word_s = bus.latch_data; state_s = ST_WAIT; end
`ifdef DEBUG_CHECKSUM_EN
      ST_SEND_CSUM:  begin word_s = csum_r;         state_s = ST_WAIT; end
`endif
      ST_WAIT: begin
        if (ready_ok_s) begin
          case (cur_send_r)
            ST_SEND_PC:    state_s = ST_SEND_REG;
            ST_SEND_REG:   state_s = (reg_addr_r == REG_LAST) ? ST_SEND_MEM : ST_SEND_REG;
            ST_SEND_MEM:   state_s = (mem_addr_r == MEM_LAST) ? ST_SEND_LATCH : ST_SEND_MEM;
`ifdef DEBUG_CHECKSUM_EN
            ST_SEND_LATCH: state_s = walk_last_s ? ST_SEND_CSUM : ST_SEND_LATCH;
`else
            ST_SEND_LATCH: state_s = walk_last_s ? ST_DONE : ST_SEND_LATCH;
`endif
            default:       state_s = ST_DONE;
          endcase
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE:       state_s = from_run_r ? ST_RUN : ST_IDLE;
      default:       state_s = ST_IDLE;
    endcase
    dump_start_s = (state_s == ST_SEND_PC) && (state_r != ST_SEND_PC);
  end

  // State, return bookkeeping and registered status/transmit outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cur_send_r <= ST_IDLE;
      from_run_r <= 1'b0;
      tx_start_r <= 1'b0;
      tx_data_r  <= '0;
      debug_on_r <= 1'b0;
      stop_pc_r  <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cur_send_r <= is_send(state_r) ? state_r : cur_send_r;
      if (dump_start_s) begin
        from_run_r <= (state_r == ST_RUN);
      end
      tx_start_r <= is_send(state_r);
      if (is_send(state_r)) begin
        tx_data_r <= word_s;
      end
      debug_on_r <= is_send(state_s) || (state_s == ST_WAIT);
      stop_pc_r  <= !((state_s == ST_RUN) || (state_s == ST_STEP));
      busy_r     <= !((state_s == ST_IDLE) || (state_s == ST_RUN));
    end
  end

  // Register and memory read addresses; they move only when a word is retired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_addr_r <= '0;
      mem_addr_r <= '0;
    end else if (state_r == ST_DONE) begin
      reg_addr_r <= '0;
      mem_addr_r <= '0;
    end else if (dump_start_s) begin
      reg_addr_r <= '0;
      mem_addr_r <= MEM_BASE;
    end else if (ready_ok_s && (cur_send_r == ST_SEND_REG)) begin
      reg_addr_r <= (reg_addr_r == REG_LAST) ? '0 : reg_addr_r + REG_AW'(1);
    end else if (ready_ok_s && (cur_send_r == ST_SEND_MEM)) begin
      mem_addr_r <= (mem_addr_r == MEM_LAST) ? '0 : mem_addr_r + DATA_W'(1);
    end
  end

`ifdef DEBUG_CHECKSUM_EN
  // Running XOR of every word sent in this dump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_r <= '0;
    end else if (dump_start_s) begin
      csum_r <= '0;
    end else if (is_send(state_r) && (state_r != ST_SEND_CSUM)) begin
      csum_r <= csum_r ^ word_s;
    end
  end
`endif

  assign bus.reg_addr    = reg_addr_r;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.latch_stage = walk_stage_s;
  assign bus.latch_sig   = walk_sig_s;
  assign bus.tx_start    = tx_start_r;
  assign bus.tx_data     = tx_data_r;
  assign bus.debug_on    = debug_on_r;
  assign bus.stop_pc     = stop_pc_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Self-checking bench for debug_dump_sequencer: command table plus scoreboarded dumps.
module tb_debug_dump_sequencer;
  import debug_pkg::*;

  logic clk;
  logic rst;
  debug_dump_sequencer_if #(.DATA_W(32), .REG_AW(5)) bus ();

  debug_dump_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.reg_data   = 32'hA5A5_0000 ^ {27'd0, bus.reg_addr};
  assign bus.mem_data   = 32'h5A00_0000 ^ bus.mem_addr;
  assign bus.latch_data = {16'hC0DE, 5'd0, bus.latch_stage, 4'd0, bus.latch_sig};

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q[$];
  int          words_seen = 0;
  int          low_cycles = 0;
  bit          coinc = 1'b0;

  typedef struct {
    logic [7:0] cmd;
    logic       exp_stop;
    logic       exp_busy;
  } cmd_vec_t;
  cmd_vec_t vecs[10];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected word stream of one dump, built from the bench's own memory model.
  task automatic push_dump(input logic [31:0] pcv);
    int lims[5] = '{2, 4, 6, 6, 2};
    logic [31:0] x;
    x = pcv;
    q.push_back(pcv);
    for (int r = 0; r < 32; r++) begin
      q.push_back(32'hA5A5_0000 ^ r);
      x = x ^ (32'hA5A5_0000 ^ r);
    end
    for (int m = 0; m < 20; m++) begin
      q.push_back(32'h5A00_0000 ^ m);
      x = x ^ (32'h5A00_0000 ^ m);
    end
    for (int s = 0; s < 5; s++) begin
      for (int g = 0; g < lims[s]; g++) begin
        q.push_back({16'hC0DE, 5'd0, 3'(s), 4'd0, 4'(g)});
        x = x ^ {16'hC0DE, 5'd0, 3'(s), 4'd0, 4'(g)};
      end
    end
`ifdef DEBUG_CHECKSUM_EN
    q.push_back(x);
`endif
  endtask

  // One-cycle command strobe; optionally queue the dump it starts (pc + pc_off).
  task automatic send_cmd(input logic [7:0] b, input bit push, input logic [31:0] pc_off);
    @(negedge clk);
    if (push) push_dump(bus.pc + pc_off);
    bus.cmd_valid = 1'b1;
    bus.cmd       = b;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd       = 8'h00;
  endtask

  task automatic wait_idle(input string nm, input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (!bus.busy && q.size() == 0) done = 1'b1;
    end
    check({nm, "_finished"}, {31'd0, done}, 32'd1);
    check({nm, "_left_words"}, q.size(), 32'd0);
  endtask

  task automatic wait_words(input int n, input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (words_seen >= n) done = 1'b1;
    end
    check("word_count_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string nm, input logic exp_stop);
    check({nm, "_stop_pc"}, {31'd0, bus.stop_pc}, {31'd0, exp_stop});
    check({nm, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({nm, "_debug_on"}, {31'd0, bus.debug_on}, 32'd0);
    check({nm, "_tx_start"}, {31'd0, bus.tx_start}, 32'd0);
    check({nm, "_selects"}, {bus.reg_addr, bus.mem_addr[19:0], bus.latch_stage, bus.latch_sig}, 32'd0);
  endtask

  // Processor model: pc advances by 4 for every clock with stop_pc low.
  initial begin
    bit run;
    bus.pc = 32'h0000_0100;
    forever begin
      @(negedge clk);
      run = !bus.stop_pc && !rst;
      @(posedge clk);
      #1;
      if (run) begin
        bus.pc = bus.pc + 32'd4;
        low_cycles++;
      end
    end
  end

  // UART model and scoreboard: compare each started word, ack 5 cycles later.
  initial begin
    int cnt = 0;
    bit prev = 1'b0;
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_ready = 1'b0;
      if (rst) begin
        q.delete();
        cnt  = 0;
        prev = 1'b0;
      end else begin
        if (bus.tx_start) begin
          words_seen++;
          check("tx_start_one_cycle", {31'd0, prev}, 32'd0);
          check("tx_start_before_ack", cnt, 32'd0);
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_word: got %h required no word", bus.tx_data);
          end else begin
            check($sformatf("word_%0d", words_seen), bus.tx_data, q.pop_front());
          end
          check("dump_stop_pc", {31'd0, bus.stop_pc}, 32'd1);
          check("dump_debug_on", {31'd0, bus.debug_on}, 32'd1);
          cnt = 5;
          if (coinc) bus.tx_ready = 1'b1;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) bus.tx_ready = 1'b1;
        end
        prev = bus.tx_start;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int l0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 8'h00;
    vecs[0] = '{CMD_HALT, 1'b1, 1'b0};
    vecs[1] = '{8'h00,    1'b1, 1'b0};
    vecs[2] = '{8'h64,    1'b1, 1'b0};
    vecs[3] = '{CMD_RUN,  1'b0, 1'b0};
    vecs[4] = '{CMD_STEP, 1'b0, 1'b0};
    vecs[5] = '{CMD_RUN,  1'b0, 1'b0};
    vecs[6] = '{8'hFF,    1'b0, 1'b0};
    vecs[7] = '{CMD_HALT, 1'b1, 1'b0};
    vecs[8] = '{CMD_RUN,  1'b0, 1'b0};
    vecs[9] = '{CMD_HALT, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 1'b1);
    check("reset_tx_data", bus.tx_data, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Command table: run/halt control and ignored bytes.
    for (int i = 0; i < 10; i++) begin
      send_cmd(vecs[i].cmd, 1'b0, 32'd0);
      check($sformatf("tbl%0d_stop_pc", i), {31'd0, bus.stop_pc}, {31'd0, vecs[i].exp_stop});
      check($sformatf("tbl%0d_busy", i), {31'd0, bus.busy}, {31'd0, vecs[i].exp_busy});
      check($sformatf("tbl%0d_debug_on", i), {31'd0, bus.debug_on}, 32'd0);
    end

    // Dump from IDLE with a mid-dump 'H' and coincident ready pulses.
    coinc = 1'b1;
    base  = words_seen;
    send_cmd(CMD_DUMP, 1'b1, 32'd0);
    check("d_lat1_tx_start", {31'd0, bus.tx_start}, 32'd0);
    check("d_lat1_debug_on", {31'd0, bus.debug_on}, 32'd1);
    @(negedge clk);
    check("d_lat2_tx_start", {31'd0, bus.tx_start}, 32'd1);
    wait_words(base + 10, 200);
    send_cmd(CMD_HALT, 1'b0, 32'd0);
    wait_idle("dump_idle", 3000);
    coinc = 1'b0;
    check("dump_idle_count", words_seen - base, 32'd73);
    check_idle_outputs("dump_idle_end", 1'b1);

    // Run, then dump from RUN: comes back running.
    send_cmd(CMD_RUN, 1'b0, 32'd0);
    check("run_stop_pc", {31'd0, bus.stop_pc}, 32'd0);
    base = words_seen;
    send_cmd(CMD_DUMP, 1'b1, 32'd4);
    check("run_dump_stop_pc", {31'd0, bus.stop_pc}, 32'd1);
    wait_idle("dump_run", 3000);
    check("dump_run_count", words_seen - base, 32'd73);
    check_idle_outputs("dump_run_end", 1'b0);
    send_cmd(CMD_HALT, 1'b0, 32'd0);
    check("halt_stop_pc", {31'd0, bus.stop_pc}, 32'd1);

    // Step: exactly one running cycle, dumped PC is the advanced one.
    l0 = low_cycles;
    send_cmd(CMD_STEP, 1'b1, 32'd4);
    check("step_c1_stop_pc", {31'd0, bus.stop_pc}, 32'd0);
    @(negedge clk);
    check("step_c2_stop_pc", {31'd0, bus.stop_pc}, 32'd1);
    check("step_c2_tx_start", {31'd0, bus.tx_start}, 32'd0);
    @(negedge clk);
    check("step_c3_tx_start", {31'd0, bus.tx_start}, 32'd1);
    wait_idle("step", 3000);
    check("step_run_cycles", low_cycles - l0, 32'd1);
    check_idle_outputs("step_end", 1'b1);

    // Reset in the middle of a dump, then a clean restart.
    base = words_seen;
    send_cmd(CMD_DUMP, 1'b1, 32'd0);
    wait_words(base + 40, 1000);
    #1;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst", 1'b1);
    check("midrst_tx_data", bus.tx_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    base = words_seen;
    send_cmd(CMD_DUMP, 1'b1, 32'd0);
    wait_idle("restart", 3000);
    check("restart_count", words_seen - base, 32'd73);
    check_idle_outputs("restart_end", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debug_dump_sequencer.md
# debug_dump_sequencer

Command-driven debug sequencer between the MIPS pipeline and the UART wrapper. It halts or steps the processor and streams a snapshot over the UART transmit handshake, one word per transfer: PC, register file, a data-memory window and the per-stage pipeline latch signals. Word counts are set by parameters, and the behaviour is selected by command bytes received on the UART.

## Interface
Parameters:
- DATA_W, 32, width of every transmitted word and data input
- NUM_REGS, 32, register-file words dumped (addresses 0..NUM_REGS-1)
- MEM_BASE, 0, first data-memory address dumped
- MEM_WORDS, 20, data-memory words dumped
- NUM_STAGES, 5, pipeline stages dumped
- STAGE_SIGS, {4'd2,4'd6,4'd6,4'd4,4'd2}, packed signal count per stage; stage 0 is in the LSB nibble, each count is ≥1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  one-cycle strobe: cmd holds a received byte
- cmd  in  8  command byte
- pc  in  DATA_W  current PC
- reg_data  in  DATA_W  register-file read data for reg_addr (combinational)
- mem_data  in  DATA_W  data-memory read data for mem_addr (combinational)
- latch_data  in  DATA_W  latch-mux data for {latch_stage,latch_sig}
- tx_ready  in  1  one-cycle pulse: UART finished the current word
- reg_addr  out  $clog2(NUM_REGS)  register read address
- mem_addr  out  DATA_W  memory read address
- latch_stage  out  3  latch-mux stage select
- latch_sig  out  4  latch-mux signal select
- tx_start  out  1  one-cycle send request
- tx_data  out  DATA_W  word to send, held stable until tx_ready
- debug_on  out  1  high while a dump is in progress
- stop_pc  out  1  high while the processor is frozen
- busy  out  1  high whenever the state is not IDLE or RUN

## Operation
- Commands: 0x44 'D' dump (processor stays halted), 0x53 'S' step, 0x52 'R' run, 0x48 'H' halt. All other bytes are ignored.
- States: IDLE, RUN, STEP, SEND_PC, SEND_REG, SEND_MEM, SEND_LATCH, SEND_CSUM, WAIT, DONE.
- IDLE: stop_pc=1. 'R'→RUN, 'S'→STEP, 'D'→SEND_PC, 'H' is a no-op.
- RUN: stop_pc=0. 'H'→IDLE, 'D'→SEND_PC (stop_pc=1 from the next cycle). Other commands are ignored.
- STEP: stop_pc=0 for exactly one cycle, then →SEND_PC.
- Each SEND_* state loads tx_data, pulses tx_start, then goes to WAIT. The address/select counters advance on WAIT exit.
- Return state after each send:
  - SEND_PC → SEND_REG.
  - SEND_REG: after reg_addr = NUM_REGS-1 → SEND_MEM; reg_addr wraps to 0.
  - SEND_MEM: mem_addr runs MEM_BASE..MEM_BASE+MEM_WORDS-1, then → SEND_LATCH.
  - SEND_LATCH: latch_sig runs 0..STAGE_SIGS[stage]-1, then stage+1 with sig=0. After the last signal of stage NUM_STAGES-1 → SEND_CSUM (if enabled) or DONE.
- WAIT: tx_start=0. tx_ready → return state.
- DONE: debug_on=0, selects cleared, one cycle. Returns to RUN if the dump was entered from RUN, else to IDLE.
- cmd_valid is ignored in all states except IDLE and RUN.
- Word count per dump: 1+NUM_REGS+MEM_WORDS+ΣSTAGE_SIGS (73 with defaults), plus 1 with checksum.
- Reset values: stop_pc=1, tx_start=0, tx_data=0, debug_on=0, busy=0, all addresses/selects=0, state IDLE. Reset mid-dump aborts immediately, with no partial-word recovery.

## Timing
- Command to first tx_start: 2 cycles from IDLE/RUN for 'D', 3 for 'S'.
- Read addresses are stable at least 1 cycle before the SEND_* state samples the input.
- tx_start is high for exactly one cycle per word.
- tx_ready arriving in the same cycle as tx_start is ignored. Only tx_ready seen in WAIT counts.
- A cmd_valid in the DONE cycle is dropped.
- debug_on is high from the first SEND_PC cycle through the last WAIT.

## Configuration
- DEBUG_CHECKSUM_EN defined: an accumulator XORs every transmitted word. SEND_CSUM sends the accumulator as the final word, and the accumulator is cleared on SEND_PC entry.
- DEBUG_CHECKSUM_EN undefined: no accumulator and no SEND_CSUM state. SEND_LATCH goes directly to DONE.

## Structure
- Shared package debug_pkg holds:
  - the state enum
  - command byte constants CMD_DUMP/CMD_STEP/CMD_RUN/CMD_HALT
  - the default STAGE_SIGS constant
- Sub-module debug_latch_walker: the stage/signal counter pair with per-stage limit lookup and a last-signal flag, instantiated once.

## Test plan
- 'D' from IDLE, tx_ready 5 cycles after each tx_start → 73 words: PC first, regs 0..31, mem 0..19, latch (0,0)..(4,1). stop_pc stays 1 throughout; ends in IDLE.
- 'R' then 'D' → stop_pc falls 1 cycle after 'R' and rises 1 cycle after 'D'. After the dump, returns to RUN with stop_pc=0.
- 'S' from IDLE with pc incrementing while stop_pc=0 → exactly one cycle of stop_pc=0. The dumped PC equals the prior PC+4.
- 'H' sent during a dump plus a tx_ready pulse coincident with tx_start → both ignored; the word sequence is unchanged.
- rst asserted at word 40 → all outputs at reset values within the same cycle. A following 'D' restarts at PC.
- With DEBUG_CHECKSUM_EN: reg_data=addr, mem_data=0, latch_data=0, pc=0 → word 74 equals the XOR of 0..31 = 0x00000000. With pc=0x10 → word 74 = 0x00000010.
